// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - FIR tap sequencer driving the FIR-Core alu; optional saturation via FIR_SAT_EN
module fir_tap_sequencer #(
    parameter int TAPS    = 64,
    parameter int ALU_LAT = 1,
    parameter int ACC_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [15:0]        in_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [15:0]        coef_data,
    output logic                      coef_err,
    output logic signed [15:0]        alu_a,
    output logic signed [15:0]        alu_b,
    output logic [1:0]                alu_op,
    input  logic signed [31:0]        alu_result,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic signed [ACC_W-1:0]   y_data,
    output logic                      busy
);
    localparam int AW = $clog2(TAPS);
`ifdef FIR_SAT_EN
    localparam int IW = ACC_W + AW;
`else
    localparam int IW = ACC_W;
`endif
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic signed [15:0]   delay_mem [TAPS];
    logic signed [15:0]   coef_mem  [TAPS];
    logic [AW-1:0]        wp;
    logic [AW-1:0]        k;
    logic [CW-1:0]        wcnt;
    logic signed [IW-1:0] acc;
    logic signed [IW-1:0] prod_ext;
    logic [ACC_W-1:0]     acc_out;

    logic                 accept;
    logic                 last_wait;
    logic                 last_tap;
    logic [AW-1:0]        wp_next;
    logic [AW-1:0]        rd_k;
    logic [AW-1:0]        rd_idx;

    assign accept    = (state == S_IDLE) && in_valid && in_ready;
    assign last_wait = (wcnt == CW'(ALU_LAT - 1));
    assign last_tap  = (k == AW'(TAPS - 1));
    assign prod_ext  = IW'($signed(alu_result));

    // Operands for the tap about to be issued; from LOAD the pointer bump
    // has not landed yet, so the newest sample still sits at wp.
    assign wp_next = (state == S_LOAD) ? wp + AW'(1) : wp;
    assign rd_k    = (state == S_LOAD) ? '0 : k + AW'(1);
    assign rd_idx  = wp_next - AW'(1) - rd_k;

    assign busy    = (state != S_IDLE);
    assign y_valid = (state == S_DONE);

`ifdef FIR_SAT_EN
    logic fits;
    assign fits    = (acc[IW-1:ACC_W-1] == {(AW + 1){acc[IW-1]}});
    assign acc_out = fits ? acc[ACC_W-1:0] : {acc[IW-1], {(ACC_W - 1){~acc[IW-1]}}};
`else
    assign acc_out = acc;
`endif

    assign y_data = (state == S_DONE) ? acc_out : '0;

    // State register; reset aborts any operation straight back to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_LOAD;
            S_LOAD:  next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (last_wait) next_state = last_tap ? S_DONE : S_ISSUE;
            S_DONE:  if (y_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Delay line, coefficient RAM, pointers, accumulator and registered ALU operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                delay_mem[i] <= '0;
                coef_mem[i]  <= '0;
            end
            wp       <= '0;
            k        <= '0;
            wcnt     <= '0;
            acc      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= OP_IDLE;
            in_ready <= 1'b0;
            coef_err <= 1'b0;
        end else begin
            in_ready <= (next_state == S_IDLE);
            coef_err <= coef_we && (state != S_IDLE);

            if (coef_we && (state == S_IDLE)) begin
                coef_mem[coef_addr] <= coef_data;
            end

            if (accept) begin
                delay_mem[wp] <= in_data;
                acc           <= '0;
                k             <= '0;
            end

            if (state == S_LOAD) begin
                wp <= wp + AW'(1);
            end

            if (state == S_ISSUE) begin
                wcnt <= '0;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt + CW'(1);
            end

            if ((state == S_WAIT) && last_wait) begin
                acc <= acc + prod_ext;
                if (!last_tap) begin
                    k <= k + AW'(1);
                end
            end

            if (next_state == S_ISSUE) begin
                alu_a  <= delay_mem[rd_idx];
                alu_b  <= coef_mem[rd_k];
                alu_op <= OP_MUL;
            end else if (next_state == S_DONE) begin
                alu_a  <= '0;
                alu_b  <= '0;
                alu_op <= OP_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - self-checking bench for fir_tap_sequencer with an alu model and reference FIR
module tb_fir_tap_sequencer;
    localparam int TAPS    = 4;
    localparam int ALU_LAT = 1;
    localparam int ACC_W   = 32;
    localparam int AW      = $clog2(TAPS);
    localparam int LAT     = 1 + TAPS * (1 + ALU_LAT);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [15:0]    in_data;
    logic                  coef_we;
    logic [AW-1:0]         coef_addr;
    logic signed [15:0]    coef_data;
    logic                  coef_err;
    logic signed [15:0]    alu_a;
    logic signed [15:0]    alu_b;
    logic [1:0]            alu_op;
    logic signed [31:0]    alu_result;
    logic                  y_valid;
    logic                  y_ready;
    logic signed [ACC_W-1:0] y_data;
    logic                  busy;

    int n_cmp = 0;
    int n_bad = 0;

    int hist[$];
    int coefm[TAPS];

    fir_tap_sequencer #(.TAPS(TAPS), .ALU_LAT(ALU_LAT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pipelined multiplier standing in for the FIR-Core alu
    logic signed [31:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= $signed(alu_a) * $signed(alu_b);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_y();
        longint sum = 0;
        int idx;
        for (int t = 0; t < TAPS; t++) begin
            idx = hist.size() - 1 - t;
            if (idx >= 0) sum += longint'(coefm[t]) * longint'(hist[idx]);
        end
`ifdef FIR_SAT_EN
        if (sum > 64'sd2147483647) sum = 64'sd2147483647;
        if (sum < -64'sd2147483648) sum = -64'sd2147483648;
`endif
        return sum[31:0];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int t = 0; t < TAPS; t++) coefm[t] = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_busy"},     {31'b0, busy},     32'd0);
        check({tag, "_y_valid"},  {31'b0, y_valid},  32'd0);
        check({tag, "_y_data"},   y_data,            32'd0);
        check({tag, "_alu_op"},   {30'b0, alu_op},   32'd0);
        check({tag, "_alu_ab"},   {alu_a, alu_b},    32'd0);
        check({tag, "_coef_err"}, {31'b0, coef_err}, 32'd0);
    endtask

    task automatic write_coef(input int idx, input logic signed [15:0] val);
        coef_we   = 1'b1;
        coef_addr = AW'(idx);
        coef_data = val;
        @(posedge clk); #1;
        coef_we = 1'b0;
        coefm[idx] = int'(val);
        check("coef_err_idle", {31'b0, coef_err}, 32'd0);
    endtask

    task automatic send_sample(input logic signed [15:0] s, input int hold, input bit inject_we,
                               input int abort_at, output logic [31:0] yobs);
        int cnt;
        int ops;
        int waitc;
        bit seen;
        logic [31:0] exp_y;
        yobs    = 'x;
        in_data = s;
        in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        y_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        hist.push_back(int'(s));
        exp_y = model_y();
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        cnt = 0; ops = 0; seen = 0;
        while (!seen && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (alu_op == 2'b01) ops++;
            if (inject_we && cnt == 2) begin
                coef_we   = 1'b1;
                coef_addr = AW'($urandom_range(0, TAPS - 1));
                coef_data = 16'($urandom);
            end
            if (inject_we && cnt == 3) begin
                check("coef_err_pulse", {31'b0, coef_err}, 32'd1);
                coef_we = 1'b0;
            end
            if (inject_we && cnt == 4) check("coef_err_single", {31'b0, coef_err}, 32'd0);
            if (cnt == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(posedge clk); #1;
                check("abort_no_y_valid", {31'b0, y_valid}, 32'd0);
                rst = 1'b1;
                model_reset();
                return;
            end
            if (y_valid) seen = 1;
        end
        if (!seen) begin
            check("y_valid_timeout", 32'd0, 32'd1);
            return;
        end
        yobs = y_data;
        check("latency", cnt, LAT);
        check("mul_op_cycles", ops, TAPS * (1 + ALU_LAT));
        check("y_data", y_data, exp_y);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk); #1;
            check("hold_y_valid", {31'b0, y_valid}, 32'd1);
            check("hold_y_data", y_data, exp_y);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        y_ready  = 1'b1;
        @(posedge clk); #1;
        check("done_leave", {31'b0, y_valid}, 32'd0);
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] y;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; y_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic filtering with a ramp of coefficients
        for (int t = 0; t < TAPS; t++) write_coef(t, 16'(t + 1));
        send_sample(16'sd10, 0, 0, -1, y);  check("t1_y0", y, 32'd10);
        send_sample(16'sd20, 0, 0, -1, y);  check("t1_y1", y, 32'd40);
        send_sample(16'sd30, 0, 0, -1, y);  check("t1_y2", y, 32'd100);

        // Most negative sample times -1
        write_coef(0, -16'sd1);
        for (int t = 1; t < TAPS; t++) write_coef(t, 16'sd0);
        send_sample(-16'sd32768, 0, 0, -1, y);  check("t2_y", y, 32'h00008000);

        // Downstream back-pressure, then a normal sample
        for (int t = 0; t < TAPS; t++) write_coef(t, 16'($urandom));
        send_sample(16'($urandom), 5, 0, -1, y);
        send_sample(16'($urandom), 0, 0, -1, y);

        // Coefficient write while busy is dropped
        send_sample(16'($urandom), 0, 1, -1, y);
        send_sample(16'($urandom), 0, 0, -1, y);

        // Reset during ISSUE of tap 2, then zeroed coefficients
        send_sample(16'($urandom), 0, 0, 5, y);
        send_sample(16'($urandom), 0, 0, -1, y);  check("t6_y_zero", y, 32'd0);

        // Full-scale accumulation
        for (int t = 0; t < TAPS; t++) write_coef(t, 16'sd32767);
        for (int n = 0; n < 4; n++) send_sample(16'sd32767, 0, 0, -1, y);
`ifdef FIR_SAT_EN
        check("t3_y_sat", y, 32'h7FFFFFFF);
`else
        check("t3_y_wrap", y, 32'hFFFC0004);
`endif

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) write_coef($urandom_range(0, TAPS - 1), 16'($urandom));
            send_sample(16'($urandom), $urandom_range(0, 3), ($urandom_range(0, 5) == 0), -1, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
